// File: rtl/rsa_pkg.sv
// Shared widths and FSM encoding for the RSA key-generation blocks.
package rsa_pkg;

    localparam int ADDR_W_DEF = 13;
    localparam int DATA_W_DEF = 16;
    localparam int MODULUS_W  = 2 * DATA_W_DEF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR_P = 3'd1,
        S_CAP_P  = 3'd2,
        S_ADDR_Q = 3'd3,
        S_CAP_Q  = 3'd4,
        S_CHECK  = 3'd5,
        S_DONE   = 3'd6
    } pick_state_t;

endpackage

// File: rtl/prime_pair_picker.sv
// Picks two distinct primes from the prime ROM and forms their product,
// optionally stepping q forward until the modulus has its top bit set.
module prime_pair_picker
    import rsa_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int MAX_RETRY   = 16,
    parameter int REQUIRE_MSB = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   seed_a,
    input  logic [ADDR_W-1:0]   seed_b,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [DATA_W-1:0]   rom_data,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [DATA_W-1:0]   p,
    output logic [DATA_W-1:0]   q,
    output logic [2*DATA_W-1:0] n
);

    localparam int MW = 2 * DATA_W;
    localparam int RW = $clog2(MAX_RETRY + 2);

    pick_state_t       state;
    logic [ADDR_W-1:0] idx_p;
    logic [ADDR_W-1:0] idx_q;
    logic [RW-1:0]     retry;

    logic [ADDR_W-1:0] seed_inc;
    logic [ADDR_W-1:0] idx_q_inc;
    logic [ADDR_W-1:0] idx_q_step;
    logic [MW-1:0]     prod;
    logic              accept;

    // q must never land on p's entry, either at start or while stepping.
    assign seed_inc   = seed_a + ADDR_W'(1);
    assign idx_q_inc  = idx_q + ADDR_W'(1);
    assign idx_q_step = (idx_q_inc == idx_p) ? idx_q_inc + ADDR_W'(1) : idx_q_inc;

    assign prod   = MW'(p) * MW'(q);
    assign accept = (REQUIRE_MSB == 0) || prod[MW-1];

    assign rom_addr = (state == S_ADDR_P || state == S_CAP_P) ? idx_p : idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            idx_p <= '0;
            idx_q <= '0;
            retry <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            p     <= '0;
            q     <= '0;
            n     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx_p <= seed_a;
                        idx_q <= (seed_b == seed_a) ? seed_inc : seed_b;
                        retry <= '0;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        state <= S_ADDR_P;
                    end
                end
                S_ADDR_P: state <= S_CAP_P;
                S_CAP_P: begin
                    p     <= rom_data;
                    state <= S_ADDR_Q;
                end
                S_ADDR_Q: state <= S_CAP_Q;
                S_CAP_Q: begin
                    q     <= rom_data;
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    n <= prod;
                    if (accept) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (retry == RW'(MAX_RETRY)) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        retry <= retry + RW'(1);
                        idx_q <= idx_q_step;
                        state <= S_ADDR_Q;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prime_pair_picker.sv
// Scoreboard bench for prime_pair_picker with a registered-read prime ROM model.
module tb_prime_pair_picker;

    localparam int AW = 13;
    localparam int DW = 16;

    typedef struct {
        logic [DW-1:0]   p;
        logic [DW-1:0]   q;
        logic [2*DW-1:0] n;
        logic            err;
        int              lat;
        logic [AW-1:0]   addr_p;
        logic [AW-1:0]   addr_q;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [AW-1:0]   seed_a = '0;
    logic [AW-1:0]   seed_b = '0;
    logic [AW-1:0]   rom_addr;
    logic [DW-1:0]   rom_data;
    logic            busy, done, err;
    logic [DW-1:0]   p, q;
    logic [2*DW-1:0] n;

    logic            start_z = 1'b0;
    logic [AW-1:0]   seed_z = '0;
    logic [AW-1:0]   rom_addr_z;
    logic [DW-1:0]   rom_data_z;
    logic            busy_z, done_z, err_z;
    logic [DW-1:0]   p_z, q_z;
    logic [2*DW-1:0] n_z;

    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
        int i;
        i = int'(a);
        if (i < 100) return DW'(16'h4000 + i);
        return DW'(16'hC000 + 2 * i);
    endfunction

    always_ff @(posedge clk) begin
        rom_data   <= rom_fn(rom_addr);
        rom_data_z <= rom_fn(rom_addr_z);
    end

    prime_pair_picker #(.ADDR_W(AW), .DATA_W(DW), .MAX_RETRY(16), .REQUIRE_MSB(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seed_a(seed_a), .seed_b(seed_b),
        .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy), .done(done), .err(err),
        .p(p), .q(q), .n(n)
    );

    prime_pair_picker #(.ADDR_W(AW), .DATA_W(DW), .MAX_RETRY(16), .REQUIRE_MSB(0)) dut_any (
        .clk(clk), .rst_n(rst_n), .start(start_z), .seed_a(seed_z), .seed_b(seed_z),
        .rom_addr(rom_addr_z), .rom_data(rom_data_z), .busy(busy_z), .done(done_z), .err(err_z),
        .p(p_z), .q(q_z), .n(n_z)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Pops the expected record for the transaction that just finished.
    task automatic checkOutput(input logic seen, input int lat,
                               input logic [AW-1:0] a1, input logic [AW-1:0] a3,
                               input logic b1);
        exp_t e;
        chk("done_seen", 32'(seen), 32'd1);
        chk("queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("p", 32'(p), 32'(e.p));
            chk("q", 32'(q), 32'(e.q));
            chk("n", n, e.n);
            chk("err", 32'(err), 32'(e.err));
            chk("latency", 32'(lat), 32'(e.lat));
            chk("rom_addr_p", 32'(a1), 32'(e.addr_p));
            chk("rom_addr_q", 32'(a3), 32'(e.addr_q));
        end
        chk("busy_early", 32'(b1), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd0);
        @(negedge clk);
        chk("done_pulse_width", 32'(done), 32'd0);
    endtask

    // Drives one request, optionally fires a second start while busy, and waits for done.
    task automatic applyStimulus(input logic [AW-1:0] sa, input logic [AW-1:0] sb,
                                 input exp_t e, input logic extra);
        int lat;
        logic seen, b1;
        logic [AW-1:0] a1, a3;
        a1 = '0; a3 = '0; b1 = 1'b0; seen = 1'b0;
        exp_q.push_back(e);
        seed_a = sa;
        seed_b = sb;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (lat < 300) begin
            if (lat == 1) begin a1 = rom_addr; b1 = busy; end
            if (lat == 3) a3 = rom_addr;
            if (extra && lat == 2) begin start = 1'b1; seed_a = 13'd200; seed_b = 13'd0; end
            if (extra && lat == 3) start = 1'b0;
            if (done) begin seen = 1'b1; break; end
            @(negedge clk);
            lat++;
        end
        checkOutput(seen, lat, a1, a3, b1);
    endtask

    initial begin
        exp_t e;
        int lat;
        logic seen;

        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_p", 32'(p), 32'd0);
        chk("reset_q", 32'(q), 32'd0);
        chk("reset_n", n, 32'd0);
        chk("reset_rom_addr", 32'(rom_addr), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] basic pass");
        e = '{p: 16'hC258, q: 16'hC25A, n: 32'h938B02F0, err: 1'b0, lat: 6, addr_p: 13'd300, addr_q: 13'd301};
        applyStimulus(13'd300, 13'd301, e, 1'b0);

        $display("[TB] retries");
        e = '{p: 16'hC190, q: 16'hC0C8, n: 32'h91C33880, err: 1'b0, lat: 21, addr_p: 13'd200, addr_q: 13'd95};
        applyStimulus(13'd200, 13'd95, e, 1'b0);

        $display("[TB] retry budget exhausted");
        e = '{p: 16'hC190, q: 16'h4010, n: 32'(16'hC190) * 32'(16'h4010), err: 1'b1, lat: 54, addr_p: 13'd200, addr_q: 13'd0};
        applyStimulus(13'd200, 13'd0, e, 1'b0);

        $display("[TB] start while busy");
        e = '{p: 16'hC258, q: 16'hC25A, n: 32'h938B02F0, err: 1'b0, lat: 6, addr_p: 13'd300, addr_q: 13'd301};
        applyStimulus(13'd300, 13'd301, e, 1'b1);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("no_second_done", 32'(seen), 32'd0);

        $display("[TB] collision with wrap, any product accepted");
        seed_z  = 13'd8191;
        start_z = 1'b1;
        @(negedge clk);
        start_z = 1'b0;
        lat = 1;
        seen = 1'b0;
        while (lat < 300) begin
            if (done_z) begin seen = 1'b1; break; end
            @(negedge clk);
            lat++;
        end
        chk("z_done_seen", 32'(seen), 32'd1);
        chk("z_p", 32'(p_z), 32'h0000FFFE);
        chk("z_q", 32'(q_z), 32'h00004000);
        chk("z_n", n_z, 32'h3FFF8000);
        chk("z_err", 32'(err_z), 32'd0);
        chk("z_latency", 32'(lat), 32'd6);
        chk("z_rom_addr_q", 32'(rom_addr_z), 32'd0);

        $display("[TB] reset during CAP_Q");
        seed_a = 13'd300;
        seed_b = 13'd301;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_p", 32'(p), 32'd0);
        chk("abort_q", 32'(q), 32'd0);
        chk("abort_n", n, 32'd0);
        chk("abort_rom_addr", 32'(rom_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("abort_no_done", 32'(seen), 32'd0);

        $display("[TB] normal run after abort");
        e = '{p: 16'hC258, q: 16'hC25A, n: 32'h938B02F0, err: 1'b0, lat: 6, addr_p: 13'd300, addr_q: 13'd301};
        applyStimulus(13'd300, 13'd301, e, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
